// File: rtl/bridge_pkg.sv
// bridge_pkg: AHB-to-APB bridge FSM state encoding, APB address windows and PSEL one-hot codes
package bridge_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WWAIT    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_WRITEP   = 3'd4;
  localparam logic [2:0] ST_RENABLE  = 3'd5;
  localparam logic [2:0] ST_WENABLE  = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;
  localparam int NWIN = 3;
  localparam logic [31:0] WIN_BASE  [NWIN] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
  localparam logic [31:0] WIN_LIMIT [NWIN] = '{32'h83FF_FFFF, 32'h87FF_FFFF, 32'h8BFF_FFFF};
  localparam logic [2:0]  PSEL_ONEHOT [NWIN] = '{3'b001, 3'b010, 3'b100};
endpackage

// File: rtl/apb_fsm_controller_if.sv
// apb_fsm_controller_if: AHB-slave-side inputs and APB master outputs of the bridge FSM; PREADY exists only with APB_PREADY_EN
interface apb_fsm_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
);
  logic              valid, HWRITE, HWRITEreg;
  logic [ADDR_W-1:0] HADDR, HADDR_1, HADDR_2;
  logic [DATA_W-1:0] HWDATA, HWDATA_1;
`ifdef APB_PREADY_EN
  logic              PREADY;
`endif
  logic [NSLV-1:0]   PSEL;
  logic              PENABLE, PWRITE, HREADYout;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  modport master (
`ifdef APB_PREADY_EN
    input PREADY,
`endif
    input valid, HWRITE, HWRITEreg, HADDR, HADDR_1, HADDR_2, HWDATA, HWDATA_1,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout
  );
  modport slave (
`ifdef APB_PREADY_EN
    output PREADY,
`endif
    output valid, HWRITE, HWRITEreg, HADDR, HADDR_1, HADDR_2, HWDATA, HWDATA_1,
    input PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout
  );
endinterface

// File: rtl/apb_sel_decode.sv
// apb_sel_decode: combinational APB address -> one-hot PSEL, zero outside every window
module apb_sel_decode
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NSLV   = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel
);
  always_comb begin
    sel = '0;
    for (int i = 0; i < NWIN; i++)
      if (addr >= WIN_BASE[i] && addr <= WIN_LIMIT[i]) sel = NSLV'(PSEL_ONEHOT[i]);
  end
endmodule

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: AHB-to-APB bridge FSM driving registered APB master signals and HREADYout.
// APB_PREADY_EN adds a PREADY input that stretches access phases.
module apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input logic HCLK,
  input logic HRESET,
  apb_fsm_controller_if.master bus
);
  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic [NSLV-1:0]   sel, psel_d;
  logic              penable_d, pwrite_d, hready_q, hready_d, ready, idle_like, wait_acc;
`ifdef APB_PREADY_EN
  assign ready = bus.PREADY;
`else
  assign ready = 1'b1;
`endif
  assign idle_like = state inside {ST_IDLE, ST_RENABLE, ST_WENABLE};
  assign wait_acc  = ~ready && (state inside {ST_RENABLE, ST_WENABLE, ST_WENABLEP});
  // a stalled access must hold off the AHB master in the very cycle PREADY is low
  assign bus.HREADYout = hready_q & ~wait_acc;
  apb_sel_decode #(.ADDR_W(ADDR_W), .NSLV(NSLV)) u_dec (.addr(paddr_d), .sel(sel));
  always_comb begin
    state_d   = state;
    paddr_d   = bus.PADDR;
    pwdata_d  = bus.PWDATA;
    pwrite_d  = bus.PWRITE;
    psel_d    = bus.PSEL;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    if (wait_acc) begin
      penable_d = 1'b1;
      hready_d  = hready_q;
    end else if (idle_like) begin
      psel_d  = '0;
      state_d = bus.valid ? (bus.HWRITE ? ST_WWAIT : ST_READ) : ST_IDLE;
      if (bus.valid && !bus.HWRITE) begin
        paddr_d  = bus.HADDR;
        pwrite_d = 1'b0;
        psel_d   = sel;
        hready_d = 1'b0;
      end
    end else
      case (state)
        ST_WWAIT: begin
          state_d  = bus.valid ? ST_WRITEP : ST_WRITE;
          paddr_d  = bus.HADDR_1;
          pwdata_d = bus.HWDATA;
          pwrite_d = 1'b1;
          psel_d   = sel;
          hready_d = ~bus.valid;
        end
        ST_READ: begin
          state_d   = ST_RENABLE;
          penable_d = 1'b1;
        end
        ST_WRITE: begin
          state_d   = bus.valid ? ST_WENABLEP : ST_WENABLE;
          penable_d = 1'b1;
        end
        ST_WRITEP: begin
          state_d   = ST_WENABLEP;
          penable_d = 1'b1;
          hready_d  = 1'b0;
        end
        ST_WENABLEP: begin
          state_d  = !bus.HWRITEreg ? ST_READ : (bus.valid ? ST_WRITEP : ST_WRITE);
          paddr_d  = bus.HADDR_2;
          pwdata_d = bus.HWRITEreg ? bus.HWDATA_1 : bus.PWDATA;
          pwrite_d = bus.HWRITEreg;
          psel_d   = sel;
          hready_d = bus.HWRITEreg & ~bus.valid;
        end
        default: state_d = ST_IDLE;
      endcase
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state       <= ST_IDLE;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      hready_q    <= 1'b1;
    end else begin
      state       <= state_d;
      bus.PSEL    <= psel_d;
      bus.PENABLE <= penable_d;
      bus.PWRITE  <= pwrite_d;
      bus.PADDR   <= paddr_d;
      bus.PWDATA  <= pwdata_d;
      hready_q    <= hready_d;
    end
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed bridge scenarios plus random AHB traffic against a transfer-level model
module tb_apb_fsm_controller;
  logic clk = 0, rst = 0, pready = 1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();
  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (.HCLK(clk), .HRESET(rst), .bus(bus));
`ifdef APB_PREADY_EN
  assign bus.PREADY = pready;
`endif
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // transfer-level reference: each transfer start fixes the APB view, phases then follow
  typedef enum int {M_IDLE, M_WWAIT, M_READ, M_WRITE, M_WRITEP, M_RENABLE, M_WENABLE, M_WENABLEP} mst_t;
  mst_t ms = M_IDLE;
  logic [2:0]  m_psel = 0;
  logic        m_pen = 0, m_pwr = 0, m_hr = 1;
  logic [31:0] m_paddr = 0, m_pwdata = 0;
  function automatic logic [2:0] win(input logic [31:0] a);
    return (a < 32'h8000_0000 || a >= 32'h8C00_0000) ? 3'b000 : 3'b001 << ((a - 32'h8000_0000) >> 26);
  endfunction
  task automatic start_read(input logic [31:0] a);
    ms = M_READ; m_paddr = a; m_pwr = 0; m_psel = win(a); m_hr = 0;
  endtask
  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic pend);
    ms = pend ? M_WRITEP : M_WRITE; m_paddr = a; m_pwdata = d; m_pwr = 1; m_psel = win(a); m_hr = !pend;
  endtask
  task automatic model_reset();
    ms = M_IDLE; m_psel = 0; m_pen = 0; m_pwr = 0; m_hr = 1; m_paddr = 0; m_pwdata = 0;
  endtask
  function automatic logic rdy_now();
`ifdef APB_PREADY_EN
    return pready;
`else
    return 1'b1;
`endif
  endfunction
  task automatic model_step();
    if (!rdy_now() && ms inside {M_RENABLE, M_WENABLE, M_WENABLEP}) return;
    m_pen = 0; m_hr = 1;
    case (ms)
      M_WWAIT:    start_write(bus.HADDR_1, bus.HWDATA, bus.valid);
      M_READ:     begin ms = M_RENABLE; m_pen = 1; end
      M_WRITE:    begin ms = bus.valid ? M_WENABLEP : M_WENABLE; m_pen = 1; end
      M_WRITEP:   begin ms = M_WENABLEP; m_pen = 1; m_hr = 0; end
      M_WENABLEP: if (bus.HWRITEreg) start_write(bus.HADDR_2, bus.HWDATA_1, bus.valid); else start_read(bus.HADDR_2);
      default: begin
        m_psel = 0;
        if (bus.valid && !bus.HWRITE) start_read(bus.HADDR); else ms = bus.valid ? M_WWAIT : M_IDLE;
      end
    endcase
  endtask
  logic [2:0]  p_psel;
  logic        p_pwr, have_prev = 0;
  logic [31:0] p_paddr, p_pwdata;
  initial forever begin
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    if (rst) begin model_reset(); have_prev = 0; end
    chk("psel", bus.PSEL, m_psel);
    chk("penable", bus.PENABLE, m_pen);
    chk("pwrite", bus.PWRITE, m_pwr);
    chk("paddr", bus.PADDR, m_paddr);
    chk("pwdata", bus.PWDATA, m_pwdata);
    chk("hreadyout", bus.HREADYout, m_hr & ~(!rdy_now() && ms inside {M_RENABLE, M_WENABLE, M_WENABLEP}));
    chk("psel_onehot0", $onehot0(bus.PSEL), 1);
    if (have_prev) begin
      if (bus.PENABLE) begin
        chk("acc_paddr_stable", bus.PADDR, p_paddr);
        chk("acc_psel_stable", bus.PSEL, p_psel);
        chk("acc_pwdata_stable", bus.PWDATA, p_pwdata);
        chk("acc_pwrite_stable", bus.PWRITE, p_pwr);
      end
      if (!bus.PWRITE && !p_pwr) chk("pwdata_frozen_on_read", bus.PWDATA, p_pwdata);
    end
    p_psel = bus.PSEL; p_pwr = bus.PWRITE; p_paddr = bus.PADDR; p_pwdata = bus.PWDATA;
    have_prev = !rst;
  end
  // AHB slave emulation: delayed copies shift every cycle
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    @(posedge clk); #1;
    bus.HWRITEreg = bus.HWRITE; bus.HADDR_2 = bus.HADDR_1; bus.HADDR_1 = bus.HADDR; bus.HWDATA_1 = bus.HWDATA;
    bus.valid = v; bus.HWRITE = w; bus.HADDR = a; bus.HWDATA = d; pready = r;
  endtask
  task automatic idle(); step(0, 0, 0, 0, 1); endtask
  function automatic logic [31:0] raddr();
    logic [31:0] e [8] = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                           32'h87FF_FFFC, 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
    int k = $urandom_range(0, 11);
    return k < 8 ? e[k] : 32'h8000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
  endfunction
  initial begin
    bus.valid = 0; bus.HWRITE = 0; bus.HWRITEreg = 0; bus.HADDR = 0; bus.HADDR_1 = 0; bus.HADDR_2 = 0;
    bus.HWDATA = 0; bus.HWDATA_1 = 0;
    #1 rst = 1;
    #2;
    chk("rst_psel", bus.PSEL, 0); chk("rst_penable", bus.PENABLE, 0);
    chk("rst_hready", bus.HREADYout, 1); chk("rst_paddr", bus.PADDR, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // single write
    step(1, 1, 32'h8400_0004, 0, 1);
    step(0, 0, 0, 32'hDEAD_BEEF, 1); @(negedge clk);
    chk("w_wait_hready", bus.HREADYout, 1); chk("w_wait_psel", bus.PSEL, 0);
    idle(); @(negedge clk);
    chk("w_setup_psel", bus.PSEL, 3'b010); chk("w_setup_pwrite", bus.PWRITE, 1);
    chk("w_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF); chk("w_setup_paddr", bus.PADDR, 32'h8400_0004);
    chk("w_setup_penable", bus.PENABLE, 0);
    idle(); @(negedge clk);
    chk("w_acc_penable", bus.PENABLE, 1); chk("w_acc_hready", bus.HREADYout, 1);
    idle(); @(negedge clk);
    chk("w_end_psel", bus.PSEL, 0); chk("w_end_penable", bus.PENABLE, 0);
    // asynchronous reset in the middle of a write
    step(1, 1, 32'h8400_0008, 0, 1);
    step(0, 0, 0, 32'h1234_5678, 1);
    idle(); @(negedge clk);
    chk("rw_psel_before", bus.PSEL, 3'b010);
    #2 rst = 1;
    #1;
    chk("arst_psel", bus.PSEL, 0); chk("arst_penable", bus.PENABLE, 0); chk("arst_hready", bus.HREADYout, 1);
    @(posedge clk); #1 rst = 0;
    // single read right after reset release proves the FSM restarted from idle
    step(1, 0, 32'h8000_0010, 0, 1);
    idle(); @(negedge clk);
    chk("r_psel", bus.PSEL, 3'b001); chk("r_paddr", bus.PADDR, 32'h8000_0010);
    chk("r_pwrite", bus.PWRITE, 0); chk("r_penable_setup", bus.PENABLE, 0); chk("r_hready_setup", bus.HREADYout, 0);
    idle(); @(negedge clk);
    chk("r_penable", bus.PENABLE, 1); chk("r_hready", bus.HREADYout, 1);
    idle(); @(negedge clk);
    chk("r_end_psel", bus.PSEL, 0);
    // back-to-back writes
    step(1, 1, 32'h8800_0000, 0, 1);
    step(1, 1, 32'h8800_0004, 32'h0000_0011, 1);
    step(1, 1, 32'h8800_0004, 32'h0000_0022, 1); @(negedge clk);
    chk("bb_setup1_paddr", bus.PADDR, 32'h8800_0000); chk("bb_setup1_hready", bus.HREADYout, 0);
    chk("bb_setup1_psel", bus.PSEL, 3'b100); chk("bb_setup1_pwdata", bus.PWDATA, 32'h11);
    idle(); @(negedge clk);
    chk("bb_acc1_penable", bus.PENABLE, 1); chk("bb_acc1_hready", bus.HREADYout, 0);
    idle(); @(negedge clk);
    chk("bb_setup2_paddr", bus.PADDR, 32'h8800_0004); chk("bb_setup2_pwdata", bus.PWDATA, 32'h22);
    chk("bb_setup2_penable", bus.PENABLE, 0); chk("bb_setup2_hready", bus.HREADYout, 1);
    idle(); @(negedge clk);
    chk("bb_acc2_penable", bus.PENABLE, 1);
    idle(); @(negedge clk);
    chk("bb_end_psel", bus.PSEL, 0);
    // write followed by a pipelined read
    step(1, 1, 32'h8400_0010, 0, 1);
    step(1, 0, 32'h8000_0020, 32'hCAFE_F00D, 1);
    step(1, 0, 32'h8000_0020, 0, 1);
    idle(); @(negedge clk);
    chk("wr_acc_penable", bus.PENABLE, 1); chk("wr_acc_pwrite", bus.PWRITE, 1);
    idle(); @(negedge clk);
    chk("wr_rd_paddr", bus.PADDR, 32'h8000_0020); chk("wr_rd_pwrite", bus.PWRITE, 0);
    chk("wr_rd_psel", bus.PSEL, 3'b001); chk("wr_rd_pwdata", bus.PWDATA, 32'hCAFE_F00D);
    idle(); @(negedge clk);
    chk("wr_rd_penable", bus.PENABLE, 1); chk("wr_rd_hready", bus.HREADYout, 1);
    idle();
`ifdef APB_PREADY_EN
    // read stretched by three PREADY-low cycles
    step(1, 0, 32'h8000_0040, 0, 1);
    idle(); @(negedge clk);
    chk("pr_setup_psel", bus.PSEL, 3'b001);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0); @(negedge clk);
      chk("pr_wait_penable", bus.PENABLE, 1); chk("pr_wait_hready", bus.HREADYout, 0);
    end
    idle(); @(negedge clk);
    chk("pr_done_penable", bus.PENABLE, 1); chk("pr_done_hready", bus.HREADYout, 1);
    idle(); @(negedge clk);
    chk("pr_end_psel", bus.PSEL, 0); chk("pr_end_penable", bus.PENABLE, 0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), raddr(), $urandom, $urandom_range(0, 3) != 0);
    repeat (4) idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
